// File: rtl/lcd_write_arbiter.sv
// Shares the LCD character-write port between the processor and the PS2 key echo.
// Each source has a small FIFO; a round-robin scheduler issues spaced one-cycle write pulses.
module lcd_write_arbiter #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned GAP   = 2000
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       proc_wr_en,
   input  logic [7:0] proc_wr_data,
   input  logic       key_wr_en,
   input  logic [7:0] key_wr_data,
   output logic       lcd_write_en,
   output logic [7:0] lcd_write_data,
   output logic       proc_full,
   output logic       key_full,
   output logic       proc_ovf,
   output logic       key_ovf,
   output logic       busy
);
   localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = PW + 1;
   localparam int unsigned GW   = (GAP > 1) ? $clog2(GAP) : 1;
   localparam int unsigned NREQ = 2;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_e;

   // Requester 0 is the processor, requester 1 is the key echo.
   logic [7:0]      mem_q [NREQ][DEPTH];
   logic [PW-1:0]   wp_q  [NREQ];
   logic [PW-1:0]   rp_q  [NREQ];
   logic [CW-1:0]   cnt_q [NREQ];
   logic [NREQ-1:0] ovf_q;
   logic [NREQ-1:0] wr_en_c;
   logic [NREQ-1:0] full_c;
   logic [NREQ-1:0] nempty_c;
   logic [NREQ-1:0] push_c;
   logic [NREQ-1:0] pop_c;
   logic [7:0]      wr_data_c [NREQ];

   state_e        state_q;
   logic          last_key_q;
   logic          en_q;
   logic [7:0]    data_q;
   logic [GW-1:0] gap_q;

   assign wr_en_c      = {key_wr_en, proc_wr_en};
   assign wr_data_c[0] = proc_wr_data;
   assign wr_data_c[1] = key_wr_data;

   // Full is taken from the registered count, so it ignores any same-edge pop.
   always_comb begin
      full_c   = '0;
      nempty_c = '0;
      push_c   = '0;
      for (int i = 0; i < NREQ; i++) begin
         full_c[i]   = (cnt_q[i] == CW'(DEPTH));
         nempty_c[i] = (cnt_q[i] != '0);
         push_c[i]   = wr_en_c[i] & ~full_c[i];
      end
   end

   // Round-robin grant: on a tie, the requester that did not win last time goes.
   always_comb begin
      pop_c = '0;
      if (state_q == S_IDLE) begin
         if (nempty_c[0] && (!nempty_c[1] || last_key_q)) begin
            pop_c[0] = 1'b1;
         end else if (nempty_c[1]) begin
            pop_c[1] = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ovf_q <= '0;
         for (int i = 0; i < NREQ; i++) begin
            wp_q[i]  <= '0;
            rp_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREQ; i++) begin
            if (push_c[i]) wp_q[i] <= wp_q[i] + PW'(1);
            if (pop_c[i])  rp_q[i] <= rp_q[i] + PW'(1);
            if (wr_en_c[i] && full_c[i]) ovf_q[i] <= 1'b1;
            case ({push_c[i], pop_c[i]})
               2'b10:   cnt_q[i] <= cnt_q[i] + CW'(1);
               2'b01:   cnt_q[i] <= cnt_q[i] - CW'(1);
               default: cnt_q[i] <= cnt_q[i];
            endcase
         end
      end
   end

   // Storage needs no reset; only pointers and counts define occupancy.
   always_ff @(posedge clock) begin
      for (int i = 0; i < NREQ; i++) begin
         if (push_c[i]) mem_q[i][wp_q[i]] <= wr_data_c[i];
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q    <= S_IDLE;
         last_key_q <= 1'b1;
         en_q       <= 1'b0;
         data_q     <= 8'h00;
         gap_q      <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               en_q <= 1'b0;
               if (|pop_c) begin
                  data_q     <= pop_c[0] ? mem_q[0][rp_q[0]] : mem_q[1][rp_q[1]];
                  last_key_q <= pop_c[1];
                  en_q       <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               en_q    <= 1'b0;
               gap_q   <= GW'(GAP - 1);
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               en_q <= 1'b0;
               if (gap_q == '0) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_q <= gap_q - GW'(1);
               end
            end
            default: begin
               en_q    <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign lcd_write_en   = en_q;
   assign lcd_write_data = data_q;
   assign proc_full      = full_c[0];
   assign key_full       = full_c[1];
   assign proc_ovf       = ovf_q[0];
   assign key_ovf        = ovf_q[1];
   assign busy           = (state_q != S_IDLE) | (|nempty_c);

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single character-write port of the LCD controller between two requesters: the processor's LCD write strobe/data and a PS2 key-echo source.
- Each requester has a small FIFO. A round-robin scheduler drains the FIFOs and issues one-cycle write pulses to the LCD controller.
- Consecutive pulses are spaced by a programmable gap, because the LCD controller has no busy/ready signal.
- Sits between processor/PS2_Interface outputs and the lcd instance.

Parameters:
- DEPTH, 4, entries per requester FIFO; power of 2, min 2.
- GAP, 2000, idle clock cycles enforced after each LCD write pulse; min 1.

Ports:
- clock  in  1  system clock (all logic rising-edge)
- resetn  in  1  asynchronous active-low reset
- proc_wr_en  in  1  processor write request, one push per high cycle
- proc_wr_data  in  8  processor character
- key_wr_en  in  1  key-echo write request, one push per high cycle
- key_wr_data  in  8  key-echo character
- lcd_write_en  out  1  one-cycle write pulse to LCD controller
- lcd_write_data  out  8  character for LCD controller, valid while lcd_write_en=1
- proc_full  out  1  processor FIFO holds DEPTH entries
- key_full  out  1  key FIFO holds DEPTH entries
- proc_ovf  out  1  sticky: a processor push was dropped
- key_ovf  out  1  sticky: a key push was dropped
- busy  out  1  state != IDLE or either FIFO non-empty

Behaviour:
- Reset (async, resetn=0):
  - FIFOs empty; all pointers and counts = 0.
  - state=IDLE, last_grant=KEY (so the processor wins the first tie).
  - lcd_write_en=0, lcd_write_data=8'h00, full/ovf/busy=0, gap counter=0.
  - Reset mid-operation discards all queued characters and any in-progress WAIT. A pulse in progress is truncated asynchronously.
- FIFO push:
  - On a rising edge with wr_en=1 and full=0, data is written and the count increments.
  - wr_en=1 with full=1 drops the data and sets the matching ovf. Ovf clears only on reset.
  - Full is evaluated before any same-cycle pop, so a push to a full FIFO is dropped even if that FIFO is popped on the same edge.
  - Push to a non-full FIFO plus pop on the same edge: count unchanged, both take effect.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Count is log2(DEPTH)+1 bits.
- Scheduler FSM:
  - IDLE
    - If neither FIFO is non-empty: stay.
    - If exactly one is non-empty: grant it.
    - If both are non-empty: grant the one not equal to last_grant.
    - On a grant: pop the head into the lcd_write_data register, set last_grant, go to ISSUE.
  - ISSUE
    - lcd_write_en=1 for exactly this cycle; lcd_write_data holds the character.
    - Load gap counter = GAP-1; go to WAIT.
  - WAIT
    - lcd_write_en=0.
    - Counter decrements each cycle; when counter==0, go to IDLE.
    - WAIT lasts exactly GAP cycles.
  - lcd_write_data keeps its last value outside ISSUE.
- Timing:
  - A push on edge t into empty FIFOs with the FSM in IDLE gives lcd_write_en high in the cycle after edge t+1: 2-cycle latency.
  - Minimum spacing between rising edges of lcd_write_en is GAP+2 cycles (ISSUE + GAP WAIT + IDLE).
  - Ordering within a requester is strictly FIFO.
- Pushes are accepted in every FSM state; the FSM never blocks the push side.

Test Plan (GAP=4, DEPTH=4 unless noted):
1. Reset, then one proc push 8'h41 → lcd_write_en=1 exactly one cycle, 2 cycles after the push edge, data 8'h41; busy returns to 0 after 4 WAIT cycles plus IDLE.
2. Same-edge pushes: proc 8'h50, key 8'h4B, both FIFOs fresh after reset → pulses in order 8'h50 then 8'h4B, rising edges exactly 6 cycles apart.
3. Push proc 'A','B','C' and key 'x','y' in the same cycles → output sequence A,x,B,y,C (round-robin), each pulse one cycle, spacing 6.
4. Five consecutive proc pushes 8'h30..8'h34 while the FSM is held busy by a key stream → proc_full=1 after the 4th; 5th dropped; proc_ovf=1 stays set; outputs contain 30..33 only.
5. Push to a full FIFO on the same edge the FSM pops it → push dropped, ovf set, count = DEPTH-1 after that edge.
6. Assert resetn=0 mid-WAIT with 3 entries queued → all outputs 0 immediately; no further pulses after release until a new push; pointer wrap verified by 10 spaced pushes/pops producing correct data.
